// File: rtl/updi_cs_sched.sv
// UPDI control/status access scheduler.
// Arbitrates two requesters, emits SYNCH/opcode/data, and returns responses.
module updi_cs_sched #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_req_wr,
  input  logic [7:0]  i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic [1:0]  o_gnt,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [1:0]  o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE, SYNC, OPCODE, WDATA, WAIT_RX, RESP
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        win;
  logic        tx_hs;

  assign o_tx_valid = (state_q == SYNC) ||
                      (state_q == OPCODE) ||
                      (state_q == WDATA);
  assign tx_hs = o_tx_valid & i_tx_ready;

  always_comb begin
    o_tx_data = 8'h00;
    unique case (state_q)
      SYNC:    o_tx_data = 8'h55;
      OPCODE:  o_tx_data = {1'b1, wr_q, 2'b00, addr_q};
      WDATA:   o_tx_data = wdata_q;
      default: o_tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_d      = 2'b00;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    // Most recent grantee loses a tie.
    win = (i_req[0] & i_req[1]) ? ~last_q : i_req[1];
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          owner_d    = win;
          last_d     = win;
          wr_d       = win ? i_req_wr[1] : i_req_wr[0];
          addr_d     = win ? i_req_addr[7:4] : i_req_addr[3:0];
          wdata_d    = win ? i_req_wdata[15:8] : i_req_wdata[7:0];
          gnt_d[win] = 1'b1;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        if (tx_hs) state_d = OPCODE;
      end
      OPCODE: begin
        if (tx_hs) begin
          state_d = wr_q ? WDATA : WAIT_RX;
          cnt_d   = 16'h0000;
        end
      end
      WDATA: begin
        if (tx_hs) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      WAIT_RX: begin
        if (i_rx_valid) begin
          rsp_data_d = i_rx_data;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == TMAX) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 4'h0;
      wdata_q    <= 8'h00;
      gnt_q      <= 2'b00;
      cnt_q      <= 16'h0000;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_rsp_valid = (state_q == RESP) ?
                       (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_updi_cs_sched.sv
// Directed bench for updi_cs_sched.
// Linear stimulus with immediate-assertion checks.
module tb_updi_cs_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_wr = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic [1:0]  gnt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int hs = 0;
  int hs0;

  updi_cs_sched #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_gnt       (gnt),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (tx_valid && tx_ready) hs++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"}, 16'(gnt), 16'h0);
    check({tag, ".txd"}, 16'(tx_data), 16'h0);
    check({tag, ".txv"}, 16'(tx_valid), 16'h0);
    check({tag, ".rspv"}, 16'(rsp_valid), 16'h0);
    check({tag, ".rspd"}, 16'(rsp_data), 16'h0);
    check({tag, ".err"}, 16'(rsp_err), 16'h0);
    check({tag, ".busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step();
    check_zero("rst");
    rst = 1'b0;
    step();

    // write: req0 addr 3 wdata A5
    req = 2'b01; req_wr = 2'b01;
    req_addr = 8'h03; req_wdata = 16'h00A5;
    tx_ready = 1'b1;
    step();
    check("wr.gnt", 16'(gnt), 16'h1);
    check("wr.busy", 16'(busy), 16'h1);
    check("wr.sync", 16'(tx_data), 16'h55);
    check("wr.syncv", 16'(tx_valid), 16'h1);
    req = 2'b00;
    step();
    check("wr.op", 16'(tx_data), 16'hC3);
    check("wr.gnt1", 16'(gnt), 16'h0);
    step();
    check("wr.data", 16'(tx_data), 16'hA5);
    step();
    check("wr.rspv", 16'(rsp_valid), 16'h1);
    check("wr.rspd", 16'(rsp_data), 16'h00);
    check("wr.err", 16'(rsp_err), 16'h0);
    check("wr.txv", 16'(tx_valid), 16'h0);
    step();
    check("wr.idle", 16'(busy), 16'h0);
    check("wr.rspv0", 16'(rsp_valid), 16'h0);

    // read: req1 addr 0, rx 0x30 five cycles into WAIT_RX
    req = 2'b10; req_wr = 2'b00;
    req_addr = 8'h00;
    step();
    check("rd.gnt", 16'(gnt), 16'h2);
    check("rd.sync", 16'(tx_data), 16'h55);
    req = 2'b00;
    step();
    check("rd.op", 16'(tx_data), 16'h80);
    step();
    check("rd.wait.txv", 16'(tx_valid), 16'h0);
    check("rd.wait.busy", 16'(busy), 16'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rd.wait.rspv", 16'(rsp_valid), 16'h0);
    end
    rx_data = 8'h30; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("rd.rspv", 16'(rsp_valid), 16'h2);
    check("rd.rspd", 16'(rsp_data), 16'h30);
    check("rd.err", 16'(rsp_err), 16'h0);
    step();
    check("rd.idle", 16'(busy), 16'h0);
    check("rd.hold", 16'(rsp_data), 16'h30);

    // timeout: req0 read addr 5, no rx
    req = 2'b01; req_wr = 2'b00;
    req_addr = 8'h05;
    step();
    check("to.gnt", 16'(gnt), 16'h1);
    req = 2'b00;
    step();
    check("to.op", 16'(tx_data), 16'h85);
    step();
    for (int i = 1; i < 16; i++) begin
      step();
      check("to.early", 16'(rsp_valid), 16'h0);
    end
    step();
    check("to.rspv", 16'(rsp_valid), 16'h1);
    check("to.err", 16'(rsp_err), 16'h1);
    check("to.rspd", 16'(rsp_data), 16'h00);
    step();
    rx_data = 8'h77; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("to.idle.busy", 16'(busy), 16'h0);
    check("to.idle.rspv", 16'(rsp_valid), 16'h0);
    check("to.idle.rspd", 16'(rsp_data), 16'h00);
    check("to.idle.err", 16'(rsp_err), 16'h1);

    // backpressure: req1 write addr F wdata 3C
    req = 2'b10; req_wr = 2'b10;
    req_addr = 8'hF0; req_wdata = 16'h3C00;
    hs0 = hs;
    step();
    check("bp.gnt", 16'(gnt), 16'h2);
    req = 2'b00;
    step();
    check("bp.op", 16'(tx_data), 16'hCF);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.hold.d", 16'(tx_data), 16'hCF);
      check("bp.hold.v", 16'(tx_valid), 16'h1);
    end
    tx_ready = 1'b1;
    step();
    check("bp.data", 16'(tx_data), 16'h3C);
    step();
    check("bp.rspv", 16'(rsp_valid), 16'h2);
    check("bp.err", 16'(rsp_err), 16'h0);
    check("bp.hs", 16'(hs - hs0), 16'd3);
    step();

    // round robin from reset, both requesting
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 2'b11; req_wr = 2'b11;
    req_addr = 8'h21; req_wdata = 16'h2211;
    for (int t = 0; t < 4; t++) begin
      step();
      check("rr.gnt", 16'(gnt), (t % 2) ? 16'h2 : 16'h1);
      step();
      check("rr.gnt1", 16'(gnt), 16'h0);
      check("rr.op", 16'(tx_data), (t % 2) ? 16'hC2 : 16'hC1);
      step();
      check("rr.data", 16'(tx_data), (t % 2) ? 16'h22 : 16'h11);
      step();
      check("rr.rspv", 16'(rsp_valid), (t % 2) ? 16'h2 : 16'h1);
      step();
      check("rr.idle", 16'(busy), 16'h0);
    end

    // reset in WAIT_RX, then pointer back to requester 0
    req = 2'b01; req_wr = 2'b00;
    req_addr = 8'h00;
    step();
    check("rs.gnt", 16'(gnt), 16'h1);
    req = 2'b00;
    step();
    step();
    step();
    rst = 1'b1;
    rx_data = 8'h99; rx_valid = 1'b1;
    step();
    check_zero("rs");
    rst = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rs.norsp", 16'(rsp_valid), 16'h0);
    end
    req = 2'b11; req_wr = 2'b11;
    step();
    check("rs.gnt0", 16'(gnt), 16'h1);
    req = 2'b00;
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updi_cs_sched.md
# updi_cs_sched

Control/status access scheduler for the UPDI command path. It arbitrates round-robin between two requesters, host debug and NVM programmer, that each need LDCS/STCS accesses. For the granted request it emits the byte sequence SYNCH, opcode and optional data on a valid/ready byte port into the frame generator. For reads it waits, with a timeout, for the target's reply byte on the receive path, then returns a response to the owning requester.

## Interface
- TIMEOUT_CYCLES, 1024: maximum number of cycles spent in WAIT_RX before a timeout error; legal range 2..65535.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req  in  2  per-requester request; held high until the matching o_gnt bit pulses.
- i_req_wr  in  2  per-requester access type: 1 = STCS (write), 0 = LDCS (read).
- i_req_addr  in  8  per-requester CS address; requester k uses bits [4k+3:4k].
- i_req_wdata  in  16  per-requester write data; requester k uses bits [8k+7:8k].
- o_gnt  out  2  one-cycle, one-hot pulse: the request was accepted and its fields were latched.
- o_tx_data  out  8  byte to the frame generator.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  the frame generator accepts the byte; a handshake occurs when valid and ready are both high.
- i_rx_data  in  8  byte received from the target.
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
- o_rsp_valid  out  2  one-cycle pulse to the owning requester.
- o_rsp_data  out  8  read data; 0x00 for writes and on timeout.
- o_rsp_err  out  1  timeout flag, qualified by o_rsp_valid.
- o_busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SYNC, OPCODE, WDATA, WAIT_RX, RESP. All outputs are registered (Moore outputs).
- **IDLE**
  - If any i_req bit is high, the winner is chosen round-robin: the requester granted most recently has lowest priority, and after reset requester 0 wins.
  - The winner's wr, addr and wdata are latched, the pointer is updated, o_gnt[winner] is set, and the next state is SYNC.
- **SYNC:** o_tx_data=0x55, o_tx_valid=1. On handshake go to OPCODE.
- **OPCODE:**
  - o_tx_data = 0xC0|addr for a write, 0x80|addr for a read.
  - On handshake go to WDATA if the access is a write, otherwise to WAIT_RX with the timeout counter cleared.
- **WDATA:** o_tx_data = latched wdata. On handshake go to RESP with rsp_data=0x00 and err=0.
- **WAIT_RX:** o_tx_valid=0.
  - i_rx_valid: capture i_rx_data, err=0, go to RESP.
  - Otherwise, counter == TIMEOUT_CYCLES-1: data=0x00, err=1, go to RESP.
  - Otherwise: increment the counter.
- **RESP:** o_rsp_valid[owner]=1 for exactly one cycle, o_rsp_data and o_rsp_err are driven, then go to IDLE.
- Byte port rules:
  - o_tx_data and o_tx_valid stay stable while valid is high and ready is low.
  - Each byte is sent exactly once.
  - i_tx_ready is ignored when o_tx_valid=0.
- i_rx_valid is ignored in every state except WAIT_RX.
- o_rsp_data and o_rsp_err hold their last values between responses.
- A request that is still high in IDLE after RESP is treated as a new request.
- Timeout counter: 16 bits, cleared on entry to WAIT_RX, never wraps.

## Timing
- Reset: state=IDLE, round-robin pointer favours requester 0, counter=0. On the cycle after i_rst is sampled high, every output is 0: o_gnt, o_tx_data, o_tx_valid, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy.
- Reset mid-transaction aborts it. No response is issued, and the latched request is discarded.
- Request latency: a request sampled in IDLE at cycle N gives o_gnt, o_busy and o_tx_valid(0x55) at N+1.
- Write with i_tx_ready held high: SYNC N+1, OPCODE N+2, WDATA N+3, o_rsp_valid N+4, IDLE N+5 (o_busy=0).
- Read with i_tx_ready held high:
  - SYNC N+1, OPCODE N+2, WAIT_RX from N+3.
  - An rx strobe at cycle M gives o_rsp_valid at M+1.
  - With no rx strobe, o_rsp_valid (err=1) appears at N+3+TIMEOUT_CYCLES.
- An rx strobe on the final timeout cycle counts as data; err=0.
- Back-to-back: at least one IDLE cycle separates transactions.

## Test plan
- Write: requester 0, addr 3, wdata 0xA5, ready held high. Required: tx bytes 0x55, 0xC3, 0xA5; o_gnt=01 at N+1; o_rsp_valid=01 at N+4 with err=0 and data=0x00.
- Read: requester 1, addr 0; rx byte 0x30 strobed 5 cycles into WAIT_RX. Required: tx bytes 0x55, 0x80; o_rsp_valid=10 with data=0x30, err=0, one cycle after the strobe.
- Timeout: TIMEOUT_CYCLES=16, read with no rx strobe. Required: o_rsp_err=1 and data=0x00 exactly 16 cycles after entering WAIT_RX. A further rx strobe in IDLE changes nothing.
- Round-robin: both requesters request continuously from reset. Required: grants 0, 1, 0, 1; each o_gnt is a single cycle; o_rsp_valid always goes to the matching owner.
- Backpressure: i_tx_ready low for 3 cycles during OPCODE (write, addr 0xF). Required: 0xCF is held stable and transferred exactly once; WDATA follows the handshake.
- Reset in WAIT_RX. Required: outputs are 0 on the next cycle, no o_rsp_valid, and a fresh request afterwards is granted to requester 0 first.
